// File: rtl/bus_sram_slave.sv
// Burst-bus responder in front of a 2^ADDR_BITS x 32 SRAM window at BASE_ADDR.
// Read beats come from a one-word prefetch register; write back-pressure follows a fixed valid-cycle cadence.
//
// state     | meaning
// IDLE      | waiting for a begin that hits the window
// RD_WAIT   | first word being fetched, READ_WAIT extra cycles
// RD_DATA   | one read beat per cycle
// RD_END    | end-of-transaction pulse after the last read beat
// WR_DATA   | accepting write beats until the initiator ends
// ERR       | bus error pulse
// ERR_END   | end pulse; a write error holds here until the initiator ends
module bus_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          ADDR_BITS   = 9,
    parameter int          READ_WAIT   = 0,
    parameter int          BUSY_PERIOD = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int LW    = ((ADDR_BITS > 8) ? ADDR_BITS : 8) + 1;
    localparam int BCW   = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_RD_DATA, S_RD_END, S_WR_DATA, S_ERR, S_ERR_END
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [8:0]           rem_q, rem_d;
    logic [3:0]           be_q, be_d;
    logic                 wr_q, wr_d;
    logic [3:0]           wait_q, wait_d;
    logic [BCW-1:0]       bcnt_q, bcnt_d;
    logic                 eot_sent_q, eot_sent_d;
    logic                 end_seen_q, end_seen_d;

    logic [31:0] dout_q, dout_d;
    logic        dv_q, dv_d;
    logic        eot_q, eot_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        mem_we;

    logic          hit, misaligned, overrun, beat_ok;
    logic [LW-1:0] last_idx;

    assign hit        = (addressDataIn[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign misaligned = (addressDataIn[1:0] != 2'b00);
    // One bit wider than the word index so a burst running off the top cannot wrap into range.
    assign last_idx   = LW'(addressDataIn[ADDR_BITS+1:2]) + LW'(burstSizeIn);
    assign overrun    = (last_idx > LW'(DEPTH - 1));
    assign beat_ok    = dataValidIn && !busy_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        be_d       = be_q;
        wr_d       = wr_q;
        wait_d     = wait_q;
        bcnt_d     = bcnt_q;
        eot_sent_d = 1'b0;
        end_seen_d = end_seen_q;
        mem_we     = 1'b0;
        dv_d       = 1'b0;
        eot_d      = 1'b0;
        err_d      = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                end_seen_d = 1'b0;
                if (beginTransactionIn && hit) begin
                    idx_d  = addressDataIn[ADDR_BITS+1:2];
                    rem_d  = {1'b0, burstSizeIn} + 9'd1;
                    be_d   = byteEnablesIn;
                    wr_d   = !readNotWriteIn;
                    wait_d = 4'(READ_WAIT);
                    bcnt_d = '0;
                    if (misaligned || overrun)
                        state_d = S_ERR;
                    else if (readNotWriteIn)
                        state_d = S_RD_WAIT;
                    else
                        state_d = S_WR_DATA;
                end
            end
            S_RD_WAIT: begin
                if (wait_q == 4'd0)
                    state_d = S_RD_DATA;
                else
                    wait_d = wait_q - 4'd1;
            end
            S_RD_DATA: begin
                dv_d  = 1'b1;
                idx_d = idx_q + ADDR_BITS'(1);
                rem_d = rem_q - 9'd1;
                if (rem_q == 9'd1)
                    state_d = S_RD_END;
            end
            S_RD_END: begin
                eot_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_WR_DATA: begin
                if (dataValidIn)
                    bcnt_d = (bcnt_q == BCW'(BUSY_PERIOD - 1)) ? '0 : bcnt_q + BCW'(1);
                if (beat_ok && rem_q != 9'd0) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + ADDR_BITS'(1);
                    rem_d  = rem_q - 9'd1;
                end
                if (endTransactionIn)
                    state_d = S_IDLE;
                else if (beat_ok && rem_q == 9'd0)
                    state_d = S_ERR;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_ERR_END;
                if (endTransactionIn)
                    end_seen_d = 1'b1;
            end
            S_ERR_END: begin
                eot_d      = !eot_sent_q;
                eot_sent_d = 1'b1;
                if (!wr_q || endTransactionIn || end_seen_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Busy is predicted from valid cycles seen so far, so it is known before the beat arrives.
        if (BUSY_PERIOD > 0 && state_d == S_WR_DATA && bcnt_d == BCW'(BUSY_PERIOD - 1))
            busy_d = 1'b1;

        dout_d = dv_d ? rdata_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            wait_q     <= '0;
            bcnt_q     <= '0;
            eot_sent_q <= 1'b0;
            end_seen_q <= 1'b0;
            dout_q     <= '0;
            dv_q       <= 1'b0;
            eot_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            wait_q     <= wait_d;
            bcnt_q     <= bcnt_d;
            eot_sent_q <= eot_sent_d;
            end_seen_q <= end_seen_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
            eot_q      <= eot_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Contents survive reset; the read port always fetches the word needed next cycle.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b])
                    mem[idx_q][8*b +: 8] <= addressDataIn[8*b +: 8];
            end
        end
        rdata_q <= mem[idx_d];
    end

    assign addressDataOut    = dout_q;
    assign dataValidOut      = dv_q;
    assign endTransactionOut = eot_q;
    assign busErrorOut       = err_q;
    assign busyOut           = busy_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench: stimulus queues timed expected output events, negedge monitors pop and compare.
// Main DUT runs READ_WAIT=2, BUSY_PERIOD=3; a default-parameter copy is checked during the first exchange.
module tb_bus_sram_slave;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int RW = 2;
    localparam int BP = 3;

    typedef struct {
        int         cyc;
        logic [3:0] flags;   // {busy, err, eot, dv}
        logic [31:0] data;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        beginTransactionIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic [3:0]  byteEnablesIn = '0;
    logic [7:0]  burstSizeIn = '0;
    logic        readNotWriteIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;

    logic [31:0] ad_o, ad0_o;
    logic        dv_o, eot_o, err_o, busy_o;
    logic        dv0_o, eot0_o, err0_o, busy0_o;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 0;
    bit  mon0_en = 0;
    ev_t exp_q[$];
    ev_t exp0_q[$];
    logic [31:0] mdl [512];

    bus_sram_slave #(.BASE_ADDR(BASE), .ADDR_BITS(9), .READ_WAIT(RW), .BUSY_PERIOD(BP)) dut (
        .clock(clock), .reset(reset), .beginTransactionIn(beginTransactionIn),
        .addressDataIn(addressDataIn), .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
        .addressDataOut(ad_o), .dataValidOut(dv_o), .endTransactionOut(eot_o),
        .busErrorOut(err_o), .busyOut(busy_o));

    bus_sram_slave dut0 (
        .clock(clock), .reset(reset), .beginTransactionIn(beginTransactionIn),
        .addressDataIn(addressDataIn), .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
        .addressDataOut(ad0_o), .dataValidOut(dv0_o), .endTransactionOut(eot0_o),
        .busErrorOut(err0_o), .busyOut(busy0_o));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp_ev(input string nm, input ev_t e, input logic [3:0] fl, input logic [31:0] d);
        checks++;
        if (e.flags !== fl || e.data !== d) begin
            errors++;
            $display("FAIL %s event cyc=%0d: got flags=%b data=%h, expected flags=%b data=%h",
                     nm, e.cyc, fl, d, e.flags, e.data);
        end
    endtask

    always @(negedge clock) begin : mon_main
        logic [3:0] fl;
        if (mon_en) begin
            fl = {busy_o, err_o, eot_o, dv_o};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                errors++;
                $display("FAIL dut missed event cyc=%0d: expected flags=%b", exp_q[0].cyc, exp_q[0].flags);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc)
                cmp_ev("dut", exp_q.pop_front(), fl, ad_o);
            else begin
                checks++;
                if (fl !== 4'b0000) begin
                    errors++;
                    $display("FAIL dut quiet cyc=%0d: got flags=%b, expected 0000", cyc, fl);
                end
            end
            if (dv_o !== 1'b1 && ad_o !== 32'h0) begin
                errors++;
                $display("FAIL dut data idle cyc=%0d: got %h, expected 0", cyc, ad_o);
            end
        end
    end

    always @(negedge clock) begin : mon_dflt
        logic [3:0] fl;
        if (mon0_en) begin
            fl = {busy0_o, err0_o, eot0_o, dv0_o};
            while (exp0_q.size() > 0 && exp0_q[0].cyc < cyc) begin
                errors++;
                $display("FAIL dut0 missed event cyc=%0d: expected flags=%b", exp0_q[0].cyc, exp0_q[0].flags);
                void'(exp0_q.pop_front());
            end
            if (exp0_q.size() > 0 && exp0_q[0].cyc == cyc)
                cmp_ev("dut0", exp0_q.pop_front(), fl, ad0_o);
            else begin
                checks++;
                if (fl !== 4'b0000) begin
                    errors++;
                    $display("FAIL dut0 quiet cyc=%0d: got flags=%b, expected 0000", cyc, fl);
                end
            end
        end
    end

    function automatic void push(input int c, input logic [3:0] f, input logic [31:0] d);
        exp_q.push_back('{cyc: c, flags: f, data: d});
    endfunction

    function automatic void push0(input int c, input logic [3:0] f, input logic [31:0] d);
        exp0_q.push_back('{cyc: c, flags: f, data: d});
    endfunction

    function automatic bit bp_busy(input int vc);
        return (vc % BP) == (BP - 1);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string nm);
        checks++;
        if ({ad_o, dv_o, eot_o, err_o, busy_o} !== 36'h0) begin
            errors++;
            $display("FAIL %s: got data=%h dv=%b eot=%b err=%b busy=%b, expected all 0",
                     nm, ad_o, dv_o, eot_o, err_o, busy_o);
        end
    endtask

    // Beats carry base_val+k; the initiator holds a beat in any cycle the cadence marks busy.
    task automatic wr_burst(input int widx, input logic [3:0] be, input int burst, input int nbeats,
                            input logic [31:0] base_val);
        int rem, vc, k, ec;
        logic [31:0] v;
        addressDataIn = BASE + 32'(widx * 4);
        byteEnablesIn = be;
        burstSizeIn = 8'(burst);
        readNotWriteIn = 1'b0;
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        rem = burst + 1;
        vc = 0;
        k = 0;
        ec = -1;
        while (k < nbeats) begin
            v = base_val + 32'(k);
            dataValidIn = 1'b1;
            addressDataIn = v;
            if (bp_busy(vc)) begin
                push(cyc, 4'b1000, 32'h0);
            end else if (rem == 0) begin
                ec = cyc;
                k = nbeats;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[widx + burst + 1 - rem][8*b +: 8] = v[8*b +: 8];
                rem--;
                k++;
            end
            vc++;
            tick();
        end
        dataValidIn = 1'b0;
        addressDataIn = '0;
        if (ec >= 0) begin
            push(ec + 2, 4'b0100, 32'h0);
            push(ec + 3, 4'b0010, 32'h0);
            while (cyc < ec + 6) tick();
        end else if (bp_busy(vc)) begin
            push(cyc, 4'b1000, 32'h0);
        end
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        tick();
    endtask

    // stop_after >= 0: assert reset in the cycle showing that beat.
    task automatic rd_burst(input int widx, input int burst, input int stop_after);
        int t;
        addressDataIn = BASE + 32'(widx * 4);
        byteEnablesIn = 4'hF;
        burstSizeIn = 8'(burst);
        readNotWriteIn = 1'b1;
        beginTransactionIn = 1'b1;
        t = cyc + 1;
        for (int k = 0; k <= burst; k++)
            if (stop_after < 0 || k <= stop_after)
                push(t + 2 + RW + k, 4'b0001, mdl[widx + k]);
        if (stop_after < 0) push(t + 3 + RW + burst, 4'b0010, 32'h0);
        if (mon0_en) begin
            for (int k = 0; k <= burst; k++) push0(t + 2 + k, 4'b0001, mdl[widx + k]);
            push0(t + 3 + burst, 4'b0010, 32'h0);
        end
        tick();
        beginTransactionIn = 1'b0;
        readNotWriteIn = 1'b0;
        addressDataIn = '0;
        if (stop_after < 0) begin
            while (cyc < t + 3 + RW + burst) tick();
            tick();
        end else begin
            while (cyc < t + 2 + RW + stop_after) tick();
            reset = 1'b1;
            tick();
            check_quiet("reset mid-burst outputs");
            reset = 1'b0;
            tick();
        end
    endtask

    task automatic err_begin(input logic [31:0] addr, input int burst, input bit rnw);
        int t;
        addressDataIn = addr;
        byteEnablesIn = 4'hF;
        burstSizeIn = 8'(burst);
        readNotWriteIn = rnw;
        beginTransactionIn = 1'b1;
        t = cyc + 1;
        push(t + 1, 4'b0100, 32'h0);
        push(t + 2, 4'b0010, 32'h0);
        tick();
        beginTransactionIn = 1'b0;
        addressDataIn = '0;
        if (!rnw) begin
            while (cyc < t + 5) tick();
            endTransactionIn = 1'b1;
            tick();
            endTransactionIn = 1'b0;
        end else begin
            while (cyc < t + 2) tick();
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_quiet("reset outputs");
        checks++;
        if ({ad0_o, dv0_o, eot0_o, err0_o, busy0_o} !== 36'h0) begin
            errors++;
            $display("FAIL dut0 reset outputs: got data=%h, expected all 0", ad0_o);
        end
        reset = 1'b0;
        tick();
        mon_en = 1;
        mon0_en = 1;

        // single write then read of word 4; default copy must never raise busy
        wr_burst(4, 4'hF, 0, 1, 32'hDEADBEEF);
        rd_burst(4, 0, -1);
        repeat (2) tick();
        mon0_en = 0;

        // preload 0..7 and read back with wait states
        wr_burst(0, 4'hF, 7, 8, 32'h0);
        rd_burst(0, 7, -1);

        // back-pressured write, words 64..69
        wr_burst(64, 4'hF, 5, 6, 32'hC0DE0000);
        rd_burst(64, 5, -1);

        // legal burst ending exactly on the last word
        wr_burst(508, 4'hF, 3, 4, 32'hE0000000);
        rd_burst(508, 3, -1);

        // misaligned read, and write running past the top
        err_begin(BASE + 32'h2, 0, 1'b1);
        err_begin(BASE + 32'(510 * 4), 3, 1'b0);

        // overlong write: third beat must not land in word 130
        wr_burst(130, 4'hF, 0, 1, 32'h5A5A5A5A);
        wr_burst(128, 4'hF, 1, 3, 32'h12340000);
        rd_burst(128, 2, -1);

        // byte-lane merge: expected 0x11BB33DD
        wr_burst(200, 4'hF, 0, 1, 32'h11223344);
        wr_burst(200, 4'b0101, 0, 1, 32'hAABBCCDD);
        rd_burst(200, 0, -1);

        // miss: outside the 2 KiB window
        addressDataIn = BASE + 32'h800;
        burstSizeIn = 8'd0;
        readNotWriteIn = 1'b1;
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        readNotWriteIn = 1'b0;
        addressDataIn = '0;
        repeat (6) tick();
        check_quiet("miss outputs");

        // reset during beat 3, then memory still intact
        rd_burst(0, 7, 3);
        rd_burst(0, 3, -1);
        rd_burst(4, 0, -1);

        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            errors++;
            $display("FAIL pending events: got %0d/%0d left, expected 0/0", exp_q.size(), exp0_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
